fg_dac_spi_out: RTL and testbench

FG_DAC_SPI_OUT -- requirements
Module: fg_dac_spi_out

---
 rtl/fg_dac_spi_out.sv | 191 +++++++++++++++++++
 tb/tb_fg_dac_spi_out.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fg_dac_spi_out.sv
// fg_dac_spi_out: waveform-to-DAC SPI serializer.
// Adds a DC offset to each captured sample, clamps the sum to the unsigned
// waveform range, truncates it to the DAC code width and shifts out a 16-bit
// command frame in SPI mode 0. A one-entry pending register decouples the
// sample strobe from the frame rate and counts dropped samples.
module fg_dac_spi_out #(
    parameter int         WAVEFORM_BITWIDTH = 16,
    parameter int         DAC_BITWIDTH      = 12,
    parameter int         SCLK_DIV          = 2,
    parameter logic [3:0] DAC_CMD           = 4'b0011
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clk_en_i,
    input  logic                                enable_i,
    input  logic signed [WAVEFORM_BITWIDTH:0]   sample_i,
    input  logic signed [WAVEFORM_BITWIDTH:0]   offset_i,
    output logic                                sclk_o,
    output logic                                mosi_o,
    output logic                                cs_n_o,
    output logic                                busy_o,
    output logic                                frame_done_o,
    output logic [7:0]                          overrun_cnt_o
);

    localparam int W     = WAVEFORM_BITWIDTH;
    localparam int CNT_W = $clog2(2 * SCLK_DIV);

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_PULSE = CNT_W'(2 * SCLK_DIV - 2);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [4:0]          fall_cnt;
    logic [15:0]         shreg;
    logic                sclk_q;
    logic                cs_n_q;
    logic                busy_q;
    logic                done_q;
    logic [7:0]          overrun_q;

    logic signed [W:0]   pend_sample;
    logic signed [W:0]   pend_offset;
    logic                pend_valid;

    logic signed [W+1:0] sum;
    logic [W-1:0]        clamped;
    logic [15:0]         frame_next;
    logic                capture;
    logic                hold_end;
    logic                consume;

    // Offset add, clamp to [0, 2^W-1], truncate to the DAC code and build the frame
    always_comb begin
        sum = $signed({pend_sample[W], pend_sample}) + $signed({pend_offset[W], pend_offset});
        if (sum[W+1]) begin
            clamped = '0;
        end else if (sum[W]) begin
            clamped = '1;
        end else begin
            clamped = sum[W-1:0];
        end
        frame_next = {DAC_CMD, 12'b0}
                   | (16'(clamped >> (W - DAC_BITWIDTH)) << (12 - DAC_BITWIDTH));
        hold_end = (state == HOLD) && (cnt == HOLD_LAST);
        capture  = clk_en_i && enable_i;
        // The pending entry is taken either from IDLE or straight at the end of
        // HOLD, so back-to-back frames follow each other with no idle gap.
        consume  = pend_valid && ((state == IDLE) || hold_end);
    end

    // Pending sample register with overwrite-on-overrun and a saturating drop counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid  <= 1'b0;
            pend_sample <= '0;
            pend_offset <= '0;
            overrun_q   <= 8'd0;
        end else begin
            if (capture) begin
                pend_sample <= sample_i;
                pend_offset <= offset_i;
                if (pend_valid && !consume && (overrun_q != 8'hFF)) begin
                    overrun_q <= overrun_q + 8'd1;
                end
            end
            if (!enable_i) begin
                pend_valid <= 1'b0;
            end else if (capture) begin
                pend_valid <= 1'b1;
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Frame sequencer: SETUP half-period, 16 SCLK periods of SHIFT, then HOLD
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            fall_cnt <= 5'd0;
            shreg    <= 16'd0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_q <= 1'b0;
                    cs_n_q <= 1'b1;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    if (consume) begin
                        shreg  <= frame_next;
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == HALF_LAST) begin
                        cnt      <= '0;
                        sclk_q   <= 1'b1;
                        fall_cnt <= 5'd0;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (sclk_q) begin
                            sclk_q   <= 1'b0;
                            shreg    <= {shreg[14:0], 1'b0};
                            fall_cnt <= fall_cnt + 5'd1;
                        end else if (fall_cnt == 5'd16) begin
                            cs_n_q <= 1'b1;
                            shreg  <= 16'd0;
                            state  <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (consume) begin
                            shreg  <= frame_next;
                            cs_n_q <= 1'b0;
                            state  <= SETUP;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == HOLD_PULSE) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sclk_o        = sclk_q;
    assign mosi_o        = shreg[15];
    assign cs_n_o        = cs_n_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = done_q;
    assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_fg_dac_spi_out.sv
// tb_fg_dac_spi_out: directed scoreboard bench for fg_dac_spi_out with
// default parameters (16-bit waveform, 12-bit DAC, SCLK_DIV=2, command 0011).
module tb_fg_dac_spi_out;

    logic               clk_i     = 1'b0;
    logic               rst_i     = 1'b1;
    logic               clk_en_i  = 1'b0;
    logic               enable_i  = 1'b1;
    logic signed [16:0] sample_i  = '0;
    logic signed [16:0] offset_i  = '0;
    logic               sclk_o;
    logic               mosi_o;
    logic               cs_n_o;
    logic               busy_o;
    logic               frame_done_o;
    logic [7:0]         overrun_cnt_o;

    int          total       = 0;
    int          bad         = 0;
    int          cycle       = 0;
    int          frames_seen = 0;
    int          start_last  = 0;
    int          start_prev  = 0;
    logic [15:0] expq[$];

    fg_dac_spi_out dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clk_en_i      (clk_en_i),
        .enable_i      (enable_i),
        .sample_i      (sample_i),
        .offset_i      (offset_i),
        .sclk_o        (sclk_o),
        .mosi_o        (mosi_o),
        .cs_n_o        (cs_n_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Free-running cycle count used to time frame starts
    initial forever begin
        @(posedge clk_i);
        cycle++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer add, clamp to 16-bit unsigned range, keep the top 12 bits
    function automatic logic [15:0] expFrame(input int s, input int o);
        int v;
        v = s + o;
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return 16'h3000 | 16'(v >> 4);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Hold a strobe for n edges and queue the frames that are meant to go out
    task automatic applyStimulus(input int s, input int o, input int n, input int n_frames);
        sample_i = 17'(s);
        offset_i = 17'(o);
        clk_en_i = 1'b1;
        for (int k = 0; k < n_frames; k++) expq.push_back(expFrame(s, o));
        idle(n);
        clk_en_i = 1'b0;
    endtask

    task automatic waitForFrames(input int target, input string tag);
        int k;
        k = 0;
        while (frames_seen < target && k < 2000) begin
            idle(1);
            k++;
        end
        idle(2);
        checkOutput(tag, 32'(frames_seen), 32'(target));
    endtask

    // Frame monitor: collects bits on SCLK rising edges and closes a frame on frame_done
    initial begin
        int          busy_cnt;
        int          cs_cnt;
        int          bits;
        logic [15:0] rx;
        logic [15:0] e;
        logic        prev_sclk;
        logic        prev_cs_n;
        busy_cnt = 0; cs_cnt = 0; bits = 0; rx = '0;
        prev_sclk = 1'b0; prev_cs_n = 1'b1;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                busy_cnt = 0; cs_cnt = 0; bits = 0; rx = '0;
                prev_sclk = 1'b0; prev_cs_n = 1'b1;
            end else begin
                if (busy_o) busy_cnt++;
                if (!cs_n_o) cs_cnt++;
                if (prev_cs_n && !cs_n_o) begin
                    start_prev = start_last;
                    start_last = cycle;
                end
                if (!cs_n_o && sclk_o && !prev_sclk) begin
                    rx = {rx[14:0], mosi_o};
                    bits++;
                end
                if (frame_done_o) begin
                    checkOutput("frame_expected", 32'(expq.size() > 0), 32'd1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        checkOutput("frame_data", 32'(rx), 32'(e));
                    end
                    checkOutput("frame_bits", 32'(bits), 32'd16);
                    checkOutput("cs_low_cycles", 32'(cs_cnt), 32'd66);
                    checkOutput("busy_cycles", 32'(busy_cnt), 32'd70);
                    frames_seen++;
                    busy_cnt = 0; cs_cnt = 0; bits = 0; rx = '0;
                end
                prev_sclk = sclk_o;
                prev_cs_n = cs_n_o;
            end
        end
    end

    // Directed sequence
    initial begin
        int k;
        int dn;
        idle(3);
        checkOutput("rst_sclk", 32'(sclk_o), 32'd0);
        checkOutput("rst_mosi", 32'(mosi_o), 32'd0);
        checkOutput("rst_cs_n", 32'(cs_n_o), 32'd1);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_done", 32'(frame_done_o), 32'd0);
        checkOutput("rst_overrun", 32'(overrun_cnt_o), 32'd0);
        rst_i = 1'b0;
        idle(2);

        $display("[TB] basic frame");
        applyStimulus(16384, 0, 1, 1);
        waitForFrames(1, "basic_frames");

        $display("[TB] clamping");
        applyStimulus(-100, 0, 1, 1);
        waitForFrames(2, "clamp_low_frames");
        applyStimulus(65535, 16, 1, 1);
        waitForFrames(3, "clamp_high_frames");
        applyStimulus(-32, 4096, 1, 1);
        waitForFrames(4, "clamp_mid_frames");
        checkOutput("clamp_overrun", 32'(overrun_cnt_o), 32'd0);

        $display("[TB] back-to-back");
        applyStimulus(1000, 200, 1, 1);
        applyStimulus(30000, -5000, 1, 1);
        waitForFrames(6, "b2b_frames");
        checkOutput("b2b_spacing", 32'(start_last - start_prev), 32'd70);
        checkOutput("b2b_overrun", 32'(overrun_cnt_o), 32'd0);

        $display("[TB] overrun");
        applyStimulus(5000, 0, 1, 1);
        idle(9);
        applyStimulus(6000, 0, 1, 0);
        idle(9);
        applyStimulus(7000, 0, 1, 1);
        checkOutput("overrun_one", 32'(overrun_cnt_o), 32'd1);
        waitForFrames(8, "overrun_frames");
        idle(3);
        applyStimulus(20000, 100, 320, 6);
        checkOutput("overrun_sat", 32'(overrun_cnt_o), 32'd255);
        waitForFrames(14, "sat_frames");
        checkOutput("overrun_sat_hold", 32'(overrun_cnt_o), 32'd255);

        $display("[TB] reset mid-frame");
        applyStimulus(12345, -345, 1, 0);
        k = 0;
        while (cs_n_o && k < 10) begin
            idle(1);
            k++;
        end
        checkOutput("abort_frame_started", 32'(cs_n_o), 32'd0);
        idle(19);
        rst_i = 1'b1;
        idle(1);
        checkOutput("abort_cs_n", 32'(cs_n_o), 32'd1);
        checkOutput("abort_sclk", 32'(sclk_o), 32'd0);
        checkOutput("abort_busy", 32'(busy_o), 32'd0);
        checkOutput("abort_mosi", 32'(mosi_o), 32'd0);
        checkOutput("abort_overrun", 32'(overrun_cnt_o), 32'd0);
        rst_i = 1'b0;
        dn = 0;
        repeat (80) begin
            idle(1);
            if (frame_done_o) dn++;
        end
        checkOutput("abort_no_done", 32'(dn), 32'd0);
        checkOutput("abort_no_frame", 32'(frames_seen), 32'd14);
        applyStimulus(12345, -345, 1, 1);
        waitForFrames(15, "after_abort_frames");

        $display("[TB] enable drop");
        applyStimulus(40000, 0, 1, 1);
        applyStimulus(50000, 0, 1, 0);
        idle(8);
        enable_i = 1'b0;
        applyStimulus(60000, 0, 1, 0);
        idle(5);
        applyStimulus(100, 0, 3, 0);
        waitForFrames(16, "enable_drop_frames");
        idle(100);
        checkOutput("disabled_frames", 32'(frames_seen), 32'd16);
        checkOutput("disabled_busy", 32'(busy_o), 32'd0);
        checkOutput("disabled_overrun", 32'(overrun_cnt_o), 32'd0);
        enable_i = 1'b1;
        idle(100);
        checkOutput("reenabled_no_stale", 32'(frames_seen), 32'd16);
        checkOutput("queue_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
